// File: rtl/can_clk_lock_seq_if.sv
`default_nettype none
// ------------------------------------------------------------------
// can_clk_lock_seq_if : PLL-lock / CAN core reset bundle
// Rev 1.0 - initial release
// ------------------------------------------------------------------
interface can_clk_lock_seq_if #(
  parameter int BRP_WIDTH = 6
);
  logic                 locked;
  logic [BRP_WIDTH-1:0] brp;
  logic                 sys_rst;
  logic                 ready;
  logic                 tq_tick;
  logic [7:0]           lock_lost_cnt;

  modport master (
    output locked, brp,
    input  sys_rst, ready, tq_tick, lock_lost_cnt
  );

  modport slave (
    input  locked, brp,
    output sys_rst, ready, tq_tick, lock_lost_cnt
  );
endinterface
`default_nettype wire

// File: rtl/can_clk_lock_seq.sv
`default_nettype none
// ------------------------------------------------------------------
// can_clk_lock_seq : PLL-lock qualified CAN core reset + tq prescaler
// Rev 1.0 - initial release
// ------------------------------------------------------------------
module can_clk_lock_seq #(
  parameter int LOCK_STABLE_CYCLES = 4096,
  parameter int SYNC_STAGES        = 2,
  parameter int LOST_HOLD_CYCLES   = 64,
  parameter int BRP_WIDTH          = 6
) (
  input  logic              clk,
  input  logic              rst,
  can_clk_lock_seq_if.slave bus
);
  localparam int STABLE_W = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int HOLD_W   = $clog2(LOST_HOLD_CYCLES + 1);
  localparam logic [STABLE_W-1:0]  STABLE_LAST = STABLE_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [HOLD_W-1:0]    HOLD_LAST   = HOLD_W'(LOST_HOLD_CYCLES - 1);
  localparam logic [STABLE_W-1:0]  STABLE_ONE  = STABLE_W'(1);
  localparam logic [HOLD_W-1:0]    HOLD_ONE    = HOLD_W'(1);
  localparam logic [BRP_WIDTH-1:0] PRESC_ONE   = BRP_WIDTH'(1);

  localparam logic [1:0] S_WAIT_LOCK = 2'd0;
  localparam logic [1:0] S_STABLE    = 2'd1;
  localparam logic [1:0] S_RUN       = 2'd2;
  localparam logic [1:0] S_LOST      = 2'd3;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   locked_s;
  logic [1:0]             state_q, state_d;
  logic [STABLE_W-1:0]    stable_cnt_q, stable_cnt_d;
  logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d;
  logic [BRP_WIDTH-1:0]   presc_cnt_q, presc_cnt_d;
  logic [BRP_WIDTH-1:0]   brp_q, brp_d;
  logic [7:0]             lost_cnt_q, lost_cnt_d;
  logic                   sys_rst_q, sys_rst_d;
  logic                   ready_q, ready_d;
  logic                   tq_tick_q, tq_tick_d;

  // Raw locked is only ever seen by the first synchronizer flop.
  assign sync_d   = {sync_q[SYNC_STAGES-2:0], bus.locked};
  assign locked_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d      = state_q;
    stable_cnt_d = stable_cnt_q;
    hold_cnt_d   = hold_cnt_q;
    lost_cnt_d   = lost_cnt_q;
    case (state_q)
      S_WAIT_LOCK: begin
        stable_cnt_d = '0;
        if (locked_s) state_d = S_STABLE;
      end
      S_STABLE: begin
        if (!locked_s) begin
          state_d      = S_WAIT_LOCK;
          stable_cnt_d = '0;
        end else if (stable_cnt_q == STABLE_LAST) begin
          state_d      = S_RUN;
          stable_cnt_d = '0;
        end else begin
          stable_cnt_d = stable_cnt_q + STABLE_ONE;
        end
      end
      S_RUN: begin
        hold_cnt_d = '0;
        if (!locked_s) begin
          state_d = S_LOST;
          if (lost_cnt_q != 8'hFF) lost_cnt_d = lost_cnt_q + 8'd1;
        end
      end
      S_LOST: begin
        if (hold_cnt_q == HOLD_LAST) begin
          state_d    = S_WAIT_LOCK;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_ONE;
        end
      end
      default: state_d = S_WAIT_LOCK;
    endcase
  end

  // Tick is registered, so it is decided from the next-cycle counter value.
  always_comb begin
    presc_cnt_d = '0;
    brp_d       = brp_q;
    tq_tick_d   = 1'b0;
    if (state_d == S_RUN) begin
      if ((state_q != S_RUN) || (presc_cnt_q == brp_q)) begin
        brp_d     = bus.brp;
        tq_tick_d = (bus.brp == '0);
      end else begin
        presc_cnt_d = presc_cnt_q + PRESC_ONE;
        tq_tick_d   = (presc_cnt_d == brp_q);
      end
    end
    sys_rst_d = (state_d != S_RUN);
    ready_d   = (state_d == S_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q       <= '0;
      state_q      <= S_WAIT_LOCK;
      stable_cnt_q <= '0;
      hold_cnt_q   <= '0;
      presc_cnt_q  <= '0;
      brp_q        <= '0;
      lost_cnt_q   <= '0;
      sys_rst_q    <= 1'b1;
      ready_q      <= 1'b0;
      tq_tick_q    <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      state_q      <= state_d;
      stable_cnt_q <= stable_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      presc_cnt_q  <= presc_cnt_d;
      brp_q        <= brp_d;
      lost_cnt_q   <= lost_cnt_d;
      sys_rst_q    <= sys_rst_d;
      ready_q      <= ready_d;
      tq_tick_q    <= tq_tick_d;
    end
  end

  assign bus.sys_rst       = sys_rst_q;
  assign bus.ready         = ready_q;
  assign bus.tq_tick       = tq_tick_q;
  assign bus.lock_lost_cnt = lost_cnt_q;
endmodule
`default_nettype wire

// File: tb/tb_can_clk_lock_seq.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_can_clk_lock_seq : directed + random bench against a phase model
// Rev 1.0 - initial release
// ------------------------------------------------------------------
module tb_can_clk_lock_seq;
  localparam int L = 16;
  localparam int H = 8;
  localparam int S = 2;

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;

  can_clk_lock_seq_if #(.BRP_WIDTH(6)) bus ();

  can_clk_lock_seq #(
    .LOCK_STABLE_CYCLES(L),
    .SYNC_STAGES       (S),
    .LOST_HOLD_CYCLES  (H),
    .BRP_WIDTH         (6)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference: phase of the core plus quantum position, advanced once per edge.
  typedef enum int {P_WAIT, P_QUAL, P_RUN, P_HOLD} phase_t;
  phase_t ph;
  int     qual, hold, losses, qlen, qpos;
  bit     sq[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    ph = P_WAIT; qual = 0; hold = 0; losses = 0; qlen = 1; qpos = 0;
    sq = {};
    repeat (S) sq.push_back(1'b0);
  endtask

  task automatic model_edge();
    bit ls;
    if (rst) begin
      model_reset();
      return;
    end
    ls = sq.pop_front();
    sq.push_back(bus.locked);
    case (ph)
      P_WAIT: if (ls) begin ph = P_QUAL; qual = 0; end
      P_QUAL: begin
        if (!ls) ph = P_WAIT;
        else begin
          qual = qual + 1;
          if (qual == L) begin ph = P_RUN; qlen = int'(bus.brp) + 1; qpos = 0; end
        end
      end
      P_RUN: begin
        if (!ls) begin
          ph = P_HOLD; hold = 0;
          if (losses < 255) losses = losses + 1;
        end else if (qpos == qlen - 1) begin
          qlen = int'(bus.brp) + 1; qpos = 0;
        end else qpos = qpos + 1;
      end
      P_HOLD: begin
        hold = hold + 1;
        if (hold == H) ph = P_WAIT;
      end
      default: ph = P_WAIT;
    endcase
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("sys_rst", {31'd0, bus.sys_rst}, {31'd0, ph != P_RUN});
    chk("ready",   {31'd0, bus.ready},   {31'd0, ph == P_RUN});
    chk("tq_tick", {31'd0, bus.tq_tick}, {31'd0, (ph == P_RUN) && (qpos == qlen - 1)});
    chk("lost_cnt", {24'd0, bus.lock_lost_cnt}, losses);
  endtask

  // Steps until ready equals val (bounded); n = edges taken.
  task automatic wait_ready(input logic val, input int max, input string tag, output int n);
    n = 0;
    while (bus.ready !== val && n < max) begin
      step();
      n++;
    end
    chk(tag, {31'd0, bus.ready}, {31'd0, val});
  endtask

  initial begin
    int n;
    int mask;
    model_reset();
    rst = 1'b1; bus.locked = 1'b0; bus.brp = 6'd0;

    // Reset held with locked low
    repeat (3) step();
    chk("rst_cnt", {24'd0, bus.lock_lost_cnt}, 32'd0);

    // Plain lock latency
    rst = 1'b0;
    repeat (2) step();
    bus.locked = 1'b1;
    wait_ready(1'b1, 40, "lock_seen", n);
    chk("lock_latency", n, 32'd19);

    // Glitch during qualification restarts the count
    rst = 1'b1; bus.locked = 1'b0; step();
    rst = 1'b0; step();
    bus.locked = 1'b1; repeat (10) step();
    bus.locked = 1'b0; step();
    bus.locked = 1'b1; bus.brp = 6'd3;
    wait_ready(1'b1, 40, "relock_seen", n);
    chk("glitch_latency", n, 32'd19);
    chk("glitch_cnt", {24'd0, bus.lock_lost_cnt}, 32'd0);

    // Prescaler pattern, brp 3 then 0 mid-quantum
    mask = 0;
    for (int c = 0; c < 13; c++) begin
      if (bus.tq_tick) mask = mask | (1 << c);
      if (c == 5) bus.brp = 6'd0;
      step();
    end
    chk("tq_pattern", mask, 32'h1F88);

    // Single sampled lock loss in RUN
    bus.locked = 1'b0; step();
    bus.locked = 1'b1; step();
    chk("loss_ready_hold", {31'd0, bus.ready}, 32'd1);
    step();
    chk("loss_ready_drop", {31'd0, bus.ready}, 32'd0);
    chk("loss_cnt", {24'd0, bus.lock_lost_cnt}, 32'd1);
    wait_ready(1'b1, 60, "loss_relock_seen", n);
    chk("loss_relock", n, 32'd25);

    // Random locked / brp / occasional rst
    for (int i = 0; i < 4000; i++) begin
      if (bus.locked ? ($urandom_range(0, 59) == 0) : ($urandom_range(0, 3) == 0))
        bus.locked = ~bus.locked;
      if ($urandom_range(0, 15) == 0) bus.brp = 6'($urandom_range(0, 7));
      rst = ($urandom_range(0, 999) == 0);
      step();
    end

    // Saturation of the loss counter
    rst = 1'b1; bus.locked = 1'b1; bus.brp = 6'($urandom_range(0, 5)); step();
    rst = 1'b0;
    wait_ready(1'b1, 40, "sat_start", n);
    for (int k = 0; k < 260; k++) begin
      bus.locked = 1'b0; step();
      bus.locked = 1'b1;
      wait_ready(1'b0, 10, "sat_drop", n);
      wait_ready(1'b1, 40, "sat_rise", n);
    end
    chk("sat_cnt", {24'd0, bus.lock_lost_cnt}, 32'd255);

    // rst while qualifying clears the counter
    bus.locked = 1'b0; step();
    bus.locked = 1'b1;
    repeat (15) step();
    rst = 1'b1; step();
    rst = 1'b0;
    chk("rst_mid_cnt", {24'd0, bus.lock_lost_cnt}, 32'd0);
    chk("rst_mid_sys_rst", {31'd0, bus.sys_rst}, 32'd1);
    wait_ready(1'b1, 40, "post_rst_lock", n);
    chk("post_rst_latency", n, 32'd19);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/can_clk_lock_seq.md
Name: can_clk_lock_seq

Overview:
- Sits directly downstream of the 50→40 MHz CAN PLL and runs on its 40 MHz output clock.
- Turns the PLL's asynchronous `locked` flag into a clean, stable-qualified synchronous reset for the CAN core.
- Counts lock-loss events.
- Generates the CAN time-quantum enable (`tq_tick`) from the 40 MHz clock through a programmable baud-rate prescaler.

Parameters:
- LOCK_STABLE_CYCLES, 4096: consecutive synchronized-locked cycles required before the core is released.
- SYNC_STAGES, 2: flops in the `locked` synchronizer; minimum 2.
- LOST_HOLD_CYCLES, 64: minimum cycles `sys_rst` is held after a lock loss in RUN.
- BRP_WIDTH, 6: width of the baud-rate prescaler input.

Ports:
- clk  in  1  40 MHz PLL output clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- locked  in  1  PLL lock flag; asynchronous to clk.
- brp  in  BRP_WIDTH  prescaler; time quantum = (brp+1) clk cycles.
- sys_rst  out  1  synchronous active-high reset to the CAN core.
- ready  out  1  high only in RUN.
- tq_tick  out  1  one-cycle time-quantum enable.
- lock_lost_cnt  out  8  saturating count of lock losses seen in RUN.

Behaviour:
- Reset is synchronous and active-high (`rst` sampled on the rising edge of `clk`). All outputs are registered.
- Reset values:
  - synchronizer flops 0
  - state WAIT_LOCK
  - sys_rst=1, ready=0, tq_tick=0
  - lock_lost_cnt=0
  - stable counter 0, hold counter 0, prescaler counter 0
- `locked` passes through SYNC_STAGES flops to give `locked_s`. Nothing else samples raw `locked`.
- FSM states: WAIT_LOCK, STABLE, RUN, LOST.
- WAIT_LOCK:
  - sys_rst=1, ready=0.
  - Go to STABLE when locked_s=1; stable counter cleared to 0.
- STABLE:
  - sys_rst=1.
  - Stable counter increments each cycle.
  - locked_s=0 → WAIT_LOCK, counter cleared, lock_lost_cnt unchanged.
  - Counter == LOCK_STABLE_CYCLES-1 with locked_s=1 → RUN.
- RUN:
  - sys_rst=0 and ready=1 starting with the first RUN cycle.
  - locked_s=0 → LOST at the next edge; sys_rst=1 and ready=0 in the first LOST cycle.
  - lock_lost_cnt increments by 1 on that transition, saturating at 255.
- LOST:
  - sys_rst=1; `locked_s` is ignored.
  - Hold counter counts 0..LOST_HOLD_CYCLES-1, then → WAIT_LOCK.
- Latency: `locked` rising and held → `ready` rising after exactly SYNC_STAGES+1+LOCK_STABLE_CYCLES edges, counted from the first edge that samples `locked`=1.
- Prescaler:
  - Active only in RUN; counter forced to 0 and tq_tick=0 in every other state.
  - brp is captured into brp_q on RUN entry and at each wrap.
  - Counter counts 0..brp_q. tq_tick=1 in the cycle the counter equals brp_q, then the counter wraps to 0.
  - First tick occurs in RUN cycle index brp (0-based), i.e. brp+1 cycles after sys_rst falls.
  - brp=0: tq_tick high every RUN cycle.
  - brp changed mid-quantum: the current quantum finishes with the old value; the new value applies from the next quantum.
- Simultaneous events:
  - rst has priority over everything.
  - Lock loss in the same cycle as a prescaler wrap: that tick is still issued; tq_tick=0 from the first LOST cycle.
- rst mid-operation:
  - Returns to WAIT_LOCK with sys_rst=1 at the next edge.
  - lock_lost_cnt is cleared only by rst.

Test Plan (LOCK_STABLE_CYCLES=16, LOST_HOLD_CYCLES=8, SYNC_STAGES=2):
1. rst for 3 cycles, locked=0 → sys_rst=1, ready=0, tq_tick=0, lock_lost_cnt=0 throughout.
2. Release rst, raise locked at edge N and hold → ready=1 and sys_rst=0 first observed at edge N+19; no earlier transition.
3. locked high for 10 cycles, low 1 cycle (long enough to be sampled), then high → no release at N+19; release 19 edges after the re-rise; lock_lost_cnt=0.
4. In RUN, brp=3 → tq_tick at RUN cycles 3, 7, 11, …; change brp to 0 at RUN cycle 5 → tick at 7, then every cycle from 8.
5. In RUN, drop locked for 1 sampled cycle → sys_rst=1 and ready=0 at locked_s fall +1; lock_lost_cnt=1; LOST for 8 cycles then WAIT_LOCK; re-lock releases after 1+16 further edges.
6. Force 260 RUN→LOST losses → lock_lost_cnt saturates at 255; assert rst mid-STABLE → WAIT_LOCK, lock_lost_cnt=0.
